// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Loads one core configuration chain from a word-wide bitstream stream.
//   Words arrive over a valid/ready handshake. Each word is serialized
//   MSB-first onto ccff_head. chain_shift_en qualifies the progclk edges on
//   which the chain shifts. Exactly CHAIN_LENGTH bits are shifted per load.
//   If CHAIN_LENGTH is not a multiple of WORD_WIDTH, the unused LSBs of the
//   last word are dropped.
//
// Ports
//   progclk         programming clock; all state moves on its rising edge
//   pReset          asynchronous active-low reset
//   start           begins a load; honoured only in IDLE or DONE
//   abort           cancels a load (LOAD) or leaves DONE; returns to IDLE
//   word_valid      word_data carries a bitstream word
//   word_data       bitstream word; the MSB is shifted first
//   word_ready      the loader takes word_data on this edge if word_valid=1
//   ccff_head       serial data to the chain head
//   chain_shift_en  the chain shifts on this progclk edge
//   busy            a load is in progress
//   done            the chain holds CHAIN_LENGTH freshly loaded bits
//   bits_remaining  bits still to shift in the current load

module config_chain_loader #(
    parameter int  CHAIN_LENGTH = 2250,
    parameter int  WORD_WIDTH   = 32,
    localparam int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  progclk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_ready,
    output logic                  ccff_head,
    output logic                  chain_shift_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  bits_remaining
);

    localparam int BCNT_WIDTH = $clog2(WORD_WIDTH + 1);
    // One spare bit, so both counters zero-extend into a common compare width.
    localparam int CMP_WIDTH  = ((CNT_WIDTH > BCNT_WIDTH) ? CNT_WIDTH : BCNT_WIDTH) + 1;

    localparam logic [CNT_WIDTH-1:0]  CHAIN_LEN_C = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [CNT_WIDTH-1:0]  REM_ONE_C   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  REM_ZERO_C  = CNT_WIDTH'(0);
    localparam logic [BCNT_WIDTH-1:0] WORD_LEN_C  = BCNT_WIDTH'(WORD_WIDTH);
    localparam logic [BCNT_WIDTH-1:0] BCNT_ONE_C  = BCNT_WIDTH'(1);
    localparam logic [BCNT_WIDTH-1:0] BCNT_ZERO_C = BCNT_WIDTH'(0);
    localparam logic [WORD_WIDTH-1:0] BUF_ZERO_C  = WORD_WIDTH'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q,      state_d;
    logic [WORD_WIDTH-1:0]  buf_q,        buf_d;
    logic [BCNT_WIDTH-1:0]  bcnt_q,       bcnt_d;
    logic [CNT_WIDTH-1:0]   rem_q,        rem_d;
    logic                   word_ready_q, word_ready_d;
    logic                   shift_en_q,   shift_en_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;

    logic                   accept_s;
    logic [CMP_WIDTH-1:0]   rem_ext_s;
    logic [CMP_WIDTH-1:0]   bcnt_ext_s;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        bcnt_d     = bcnt_q;
        rem_d      = rem_q;
        accept_s   = word_valid & word_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    rem_d   = CHAIN_LEN_C;
                    buf_d   = BUF_ZERO_C;
                    bcnt_d  = BCNT_ZERO_C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rem_d   = REM_ZERO_C;
                    buf_d   = BUF_ZERO_C;
                    bcnt_d  = BCNT_ZERO_C;
                end else begin
                    if (shift_en_q) begin
                        buf_d  = {buf_q[WORD_WIDTH-2:0], 1'b0};
                        bcnt_d = bcnt_q - BCNT_ONE_C;
                        rem_d  = rem_q - REM_ONE_C;
                    end else begin
                        buf_d  = buf_q;
                        bcnt_d = bcnt_q;
                        rem_d  = rem_q;
                    end
                    // A new word can land on the same edge that shifts out the
                    // last buffered bit. That is what keeps shifting gap-free.
                    if (accept_s) begin
                        buf_d  = word_data;
                        bcnt_d = WORD_LEN_C;
                    end else begin
                        bcnt_d = bcnt_d;
                    end
                    // Final bit: drop any unused LSBs of the last word.
                    if (shift_en_q && (rem_q == REM_ONE_C)) begin
                        state_d = ST_DONE;
                        rem_d   = REM_ZERO_C;
                        buf_d   = BUF_ZERO_C;
                        bcnt_d  = BCNT_ZERO_C;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_LOAD;
                    rem_d   = CHAIN_LEN_C;
                    buf_d   = BUF_ZERO_C;
                    bcnt_d  = BCNT_ZERO_C;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = REM_ZERO_C;
                buf_d   = BUF_ZERO_C;
                bcnt_d  = BCNT_ZERO_C;
            end
        endcase

        // Outputs are computed from next-state values and registered, so
        // each output is a plain flop.
        rem_ext_s    = {{(CMP_WIDTH - CNT_WIDTH){1'b0}}, rem_d};
        bcnt_ext_s   = {{(CMP_WIDTH - BCNT_WIDTH){1'b0}}, bcnt_d};
        shift_en_d   = (state_d == ST_LOAD) && (bcnt_d != BCNT_ZERO_C);
        // Stop asking for words once the buffer already holds every bit
        // the load still needs.
        word_ready_d = (state_d == ST_LOAD)
                     && ((bcnt_d == BCNT_ZERO_C) || ((bcnt_d == BCNT_ONE_C) && shift_en_d))
                     && (rem_ext_s > bcnt_ext_s);
        busy_d       = (state_d == ST_LOAD);
        done_d       = (state_d == ST_DONE);
    end

    // State, datapath and output registers, with asynchronous reset.
    always_ff @(posedge progclk or negedge pReset) begin
        if (!pReset) begin
            state_q      <= ST_IDLE;
            buf_q        <= BUF_ZERO_C;
            bcnt_q       <= BCNT_ZERO_C;
            rem_q        <= REM_ZERO_C;
            word_ready_q <= 1'b0;
            shift_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            bcnt_q       <= bcnt_d;
            rem_q        <= rem_d;
            word_ready_q <= word_ready_d;
            shift_en_q   <= shift_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign word_ready     = word_ready_q;
    assign ccff_head      = buf_q[WORD_WIDTH-1];
    assign chain_shift_en = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign bits_remaining = rem_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader. It uses a 70-bit/32-bit instance
// and a 64-bit/32-bit instance. A shadow chain register in the bench captures
// ccff_head on each enabled edge. Inputs are driven and outputs are sampled
// on the falling edge.

module tb_config_chain_loader;

    logic        progclk = 1'b0;
    logic        pReset;
    // 70-bit instance
    logic        a_start, a_abort, a_valid;
    logic [31:0] a_data;
    logic        a_ready, a_head, a_shift, a_busy, a_done;
    logic [6:0]  a_rem;
    logic [69:0] a_chain;
    // 64-bit instance
    logic        b_start, b_abort, b_valid;
    logic [31:0] b_data;
    logic        b_ready, b_head, b_shift, b_busy, b_done;
    logic [6:0]  b_rem;
    logic [63:0] b_chain;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] words_a [3];
    logic [31:0] words_b [2];
    // 70 MSB-first bits: all of word 0, all of word 1, top 6 bits of 0xFC000000.
    logic [69:0] img70;
    logic [63:0] img64;

    always #5 progclk = ~progclk;

    config_chain_loader #(.CHAIN_LENGTH(70), .WORD_WIDTH(32)) u_dut_a (
        .progclk(progclk), .pReset(pReset), .start(a_start), .abort(a_abort),
        .word_valid(a_valid), .word_data(a_data), .word_ready(a_ready),
        .ccff_head(a_head), .chain_shift_en(a_shift), .busy(a_busy),
        .done(a_done), .bits_remaining(a_rem)
    );

    config_chain_loader #(.CHAIN_LENGTH(64), .WORD_WIDTH(32)) u_dut_b (
        .progclk(progclk), .pReset(pReset), .start(b_start), .abort(b_abort),
        .word_valid(b_valid), .word_data(b_data), .word_ready(b_ready),
        .ccff_head(b_head), .chain_shift_en(b_shift), .busy(b_busy),
        .done(b_done), .bits_remaining(b_rem)
    );

    // Shadow chains: shift in ccff_head on each qualified edge.
    always @(posedge progclk) begin
        if (a_shift) a_chain <= {a_chain[68:0], a_head};
        if (b_shift) b_chain <= {b_chain[62:0], b_head};
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_busy"},  128'(a_busy),  128'(0));
        chk({tag, "_done"},  128'(a_done),  128'(0));
        chk({tag, "_shift"}, 128'(a_shift), 128'(0));
        chk({tag, "_ready"}, 128'(a_ready), 128'(0));
        chk({tag, "_head"},  128'(a_head),  128'(0));
        chk({tag, "_rem"},   128'(a_rem),   128'(0));
    endtask

    // One load on the 70-bit instance. A stall drops word_valid after word 1.
    // abort_at / reset_at (>=0) cut the load when bits_remaining hits that value.
    task automatic run_load(input string tag, input bit stall, input int abort_at,
                            input int reset_at, input bit poke_start);
        int widx, en, first_en, last_en, done_cyc, stall_cnt;
        bit ready_late;
        widx = 0; en = 0; first_en = -1; last_en = -1; done_cyc = -1;
        stall_cnt = 0; ready_late = 1'b0;
        @(negedge progclk); a_start = 1'b1;
        @(negedge progclk); a_start = 1'b0;
        chk({tag, "_rem_start"}, 128'(a_rem), 128'(70));
        chk({tag, "_busy_start"}, 128'(a_busy), 128'(1));
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (a_done) begin
                done_cyc = cyc;
                break;
            end
            if (abort_at >= 0 && int'(a_rem) == abort_at) begin
                a_abort = 1'b1; a_valid = 1'b0;
                @(negedge progclk); a_abort = 1'b0;
                chk_idle_a({tag, "_post_abort"});
                return;
            end
            if (reset_at >= 0 && int'(a_rem) == reset_at) begin
                #2 pReset = 1'b0;
                #1 chk_idle_a({tag, "_async_rst"});
                a_valid = 1'b0;
                @(negedge progclk); pReset = 1'b1;
                return;
            end
            a_start = (poke_start && cyc == 20);
            if (stall && widx == 1 && int'(a_rem) == 38 && stall_cnt < 5) begin
                chk($sformatf("%s_stall_shift%0d", tag, stall_cnt), 128'(a_shift), 128'(0));
                chk($sformatf("%s_stall_rem%0d", tag, stall_cnt), 128'(a_rem), 128'(38));
                stall_cnt++;
            end
            a_valid = (widx < 3) && !(stall && widx == 1 && stall_cnt < 5);
            a_data  = (widx < 3) ? words_a[widx] : 32'h0;
            if (widx == 3 && a_ready) ready_late = 1'b1;
            if (a_valid && a_ready) widx++;
            if (a_shift) begin
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                en++;
            end
            @(negedge progclk);
        end
        a_start = 1'b0; a_valid = 1'b0;
        chk({tag, "_done_seen"}, 128'(done_cyc >= 0), 128'(1));
        chk({tag, "_enables"}, 128'(en), 128'(70));
        chk({tag, "_handshakes"}, 128'(widx), 128'(3));
        chk({tag, "_ready_after_last"}, 128'(ready_late), 128'(0));
        chk({tag, "_done_latency"}, 128'(done_cyc - last_en), 128'(1));
        if (!stall) chk({tag, "_consecutive"}, 128'(last_en - first_en + 1), 128'(70));
        else        chk({tag, "_stall_cycles"}, 128'(stall_cnt), 128'(5));
        chk({tag, "_image"}, 128'(a_chain), 128'(img70));
        chk({tag, "_rem_end"}, 128'(a_rem), 128'(0));
        chk({tag, "_busy_end"}, 128'(a_busy), 128'(0));
    endtask

    // Exact-multiple load on the 64-bit instance.
    task automatic run_b;
        int widx, en, done_cyc;
        widx = 0; en = 0; done_cyc = -1;
        @(negedge progclk); b_start = 1'b1;
        @(negedge progclk); b_start = 1'b0;
        chk("b_rem_start", 128'(b_rem), 128'(64));
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (b_done) begin
                done_cyc = cyc;
                break;
            end
            b_valid = (widx < 2);
            b_data  = (widx < 2) ? words_b[widx] : 32'h0;
            if (b_valid && b_ready) widx++;
            if (b_shift) en++;
            @(negedge progclk);
        end
        b_valid = 1'b0;
        chk("b_done_seen", 128'(done_cyc >= 0), 128'(1));
        chk("b_enables", 128'(en), 128'(64));
        chk("b_handshakes", 128'(widx), 128'(2));
        chk("b_image", 128'(b_chain), 128'(img64));
        chk("b_ready_end", 128'(b_ready), 128'(0));
    endtask

    initial begin
        words_a[0] = 32'hA5A5_A5A5;
        words_a[1] = 32'h0F0F_0F0F;
        words_a[2] = 32'hFC00_0000;
        words_b[0] = 32'h1234_5678;
        words_b[1] = 32'h9ABC_DEF0;
        img70 = {32'hA5A5_A5A5, 32'h0F0F_0F0F, 6'b11_1111};
        img64 = 64'h1234_5678_9ABC_DEF0;
        a_chain = 70'h0; b_chain = 64'h0;
        pReset = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_valid = 1'b0; a_data = 32'h0;
        b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = 32'h0;

        #12 chk_idle_a("reset");
        chk("reset_b_rem", 128'(b_rem), 128'(0));
        @(negedge progclk); pReset = 1'b1;
        @(negedge progclk); chk_idle_a("post_reset");

        run_load("plain", 1'b0, -1, -1, 1'b0);
        run_load("stall", 1'b1, -1, -1, 1'b0);   // started from DONE
        run_load("abort", 1'b0, 40, -1, 1'b0);
        run_load("after_abort", 1'b0, -1, -1, 1'b0);
        run_load("rst", 1'b0, -1, 50, 1'b0);
        run_load("after_rst", 1'b0, -1, -1, 1'b1); // start pulsed mid-load
        run_b();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
